// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizes for the sram_ctrl single-port memory controller.
package sram_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 13;
    localparam int DEPTH_DEF  = 8192;

    // Index width of the physical array; a one-word array still needs one bit.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_ctrl_array.sv
// Synchronous single-port storage: one shared address, one write port, one registered read port.
// The read register can be cleared synchronously so the controller can return zero for rejected reads.
module sram_ctrl_array #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 8192,
    parameter int IDX_W  = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic              rd_clr,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_p1;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // p1: read word registered one cycle after the request edge
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rdata_p1 <= '0;
        end else if (re) begin
            rdata_p1 <= mem[addr];
        end
    end

    assign rdata = rdata_p1;

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready SRAM controller: clears the array after reset, then serves reads (latency 1) and writes.
// Build option SRAM_CTRL_PARITY_EN adds an even-parity bit per word and the par_err output.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              wr_err,
    output logic              init_done
`ifdef SRAM_CTRL_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam int IDX_W = idx_w(DEPTH);
`ifdef SRAM_CTRL_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int WORD_W = DATA_W + PAR_W;

    localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   ptr_q;

    logic               accept;
    logic               addr_oor;
    logic               rd_acc;
    logic               wr_acc;

    logic               mem_we;
    logic               mem_re;
    logic               rd_clr;
    logic [IDX_W-1:0]   mem_addr;
    logic [WORD_W-1:0]  mem_wdata;
    logic [WORD_W-1:0]  mem_rdata;

    logic               vld_p1;
    logic               rd_err_p1;
    logic               wr_err_p1;

    assign accept   = req_valid & req_ready;
    // Widened by one bit so DEPTH == 2**ADDR_W compares correctly (never out of range).
    assign addr_oor = ({1'b0, req_addr} >= DEPTH_C);
    assign rd_acc   = accept & ~req_we;
    assign wr_acc   = accept &  req_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (state_q == INIT) begin
            ptr_q <= ptr_q + IDX_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && ptr_q == LAST_PTR) begin
            state_d = RUN;
        end
    end

    always_comb begin
        req_ready = 1'b0;
        init_done = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = ptr_q;
        mem_wdata = '0;
        case (state_q)
            INIT: begin
                mem_we = 1'b1;
            end
            RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
                mem_we    = wr_acc & ~addr_oor;
                mem_re    = rd_acc & ~addr_oor;
                mem_addr  = req_addr[IDX_W-1:0];
`ifdef SRAM_CTRL_PARITY_EN
                mem_wdata = {^req_wdata, req_wdata};
`else
                mem_wdata = req_wdata;
`endif
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
        // A reset edge must leave the array untouched.
        if (!rst_n) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    assign rd_clr = ~rst_n | (rd_acc & addr_oor);

    sram_ctrl_array #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (mem_we),
        .re     (mem_re),
        .rd_clr (rd_clr),
        .addr   (mem_addr),
        .wdata  (mem_wdata),
        .rdata  (mem_rdata)
    );

    // p1: response and error flags, aligned with the registered read word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            rd_err_p1 <= 1'b0;
            wr_err_p1 <= 1'b0;
        end else begin
            vld_p1    <= rd_acc;
            rd_err_p1 <= rd_acc & addr_oor;
            wr_err_p1 <= wr_acc & addr_oor;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_err   = rd_err_p1;
    assign wr_err    = wr_err_p1;
    assign rsp_rdata = mem_rdata[DATA_W-1:0];
`ifdef SRAM_CTRL_PARITY_EN
    assign par_err   = vld_p1 & (^mem_rdata);
`endif

endmodule
